proj_kmer_window: RTL and testbench

Streaming k-mer window generator with valid/ready handshakes on both sides. It is the parametrised successor to the fixed shift-register k-mer buffer and sits between the nucleotide input stream and the MinHash hashing stage. It emits one k-mer per accepted base once the window is full and restarts the window on ambiguous bases or end of sequence. Optionally it emits the canonical k-mer, the lesser of the forward k-mer and its reverse complement.

---
 rtl/proj_kmer_window_if.sv | 28 ++
 rtl/proj_kmer_window.sv | 137 +++++++++++++
 tb/tb_proj_kmer_window.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proj_kmer_window_if.sv
// Stream bundle for the k-mer window: the nucleotide input stream
// and the k-mer output stream, each with a valid/ready handshake.
interface proj_kmer_window_if #(
  parameter int DATA_BITS = 2,
  parameter int OUT_KMER  = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_amb;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_KMER-1:0]  out_kmer;
  logic                 out_last;

  // Upstream/downstream side: drives bases and the output ready
  modport master (
    output in_valid, in_data, in_amb, in_last, out_ready,
    input  in_ready, out_valid, out_kmer, out_last
  );

  // Window side: consumes bases and produces k-mers
  modport slave (
    input  in_valid, in_data, in_amb, in_last, out_ready,
    output in_ready, out_valid, out_kmer, out_last
  );
endinterface

// File: rtl/proj_kmer_window.sv
// Streaming k-mer window. Shifts accepted bases into a forward window
// (newest base in the LSBs) and, in canonical mode, a reverse-complement
// window. Once the window holds KMER_LEN bases every further accepted
// base emits a k-mer. Ambiguous bases restart the window; the last base
// of a sequence restarts it after the beat and flags sequences that
// never produced a k-mer.
module proj_kmer_window #(
  parameter int DATA_BITS = 2,
  parameter int KMER_LEN  = 4,
  parameter int CANON_EN  = 1,
  parameter int OUT_KMER  = KMER_LEN * DATA_BITS,
  parameter int CNT_W     = $clog2(KMER_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_over,
  proj_kmer_window_if.slave    bus,
  output logic                 short_seq,
  output logic [CNT_W-1:0]     fill_count,
  output logic                 full
);

  localparam int W = KMER_LEN * DATA_BITS;

  logic [W-1:0]        fwd_q;
  logic [W-1:0]        fwd_next;
  logic [W-1:0]        kmer_sel;
  logic [CNT_W-1:0]    fill_q;
  logic                emitted_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic                short_q;
  logic [OUT_KMER-1:0] out_kmer_q;
  logic                acc;
  logic                take;
  logic                emit;
  logic                seq_end;
  logic                restart;
  logic                fwd_unused;

  // No skid buffer: a new base is only taken when the output slot is free
  // or being drained this cycle.
  assign bus.in_ready = ~rst & ~start_over & (~out_valid_q | bus.out_ready);
  assign acc          = bus.in_valid & bus.in_ready;
  assign take         = acc & ~bus.in_amb;
  assign emit         = take & (fill_q >= CNT_W'(KMER_LEN - 1));
  assign seq_end      = acc & bus.in_last;
  assign restart      = acc & (bus.in_amb | bus.in_last);
  assign fwd_next     = {fwd_q[W-DATA_BITS-1:0], bus.in_data};
  assign fwd_unused   = ^fwd_q[W-1:W-DATA_BITS];

  generate
    if (CANON_EN != 0 && DATA_BITS != 2) begin : g_bad_cfg
      $error("proj_kmer_window: canonical mode needs 2-bit nucleotides");
    end

    if (CANON_EN != 0) begin : g_canon
      logic [W-1:0] rc_q;
      logic [W-1:0] rc_next;
      logic         rc_unused;

      assign rc_next   = {~bus.in_data, rc_q[W-1:DATA_BITS]};
      assign rc_unused = ^rc_q[DATA_BITS-1:0];
      assign kmer_sel  = (rc_next < fwd_next) ? rc_next : fwd_next;

      // Reverse-complement window: complemented base enters at the top
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rc_q <= '0;
        else if (start_over)
          rc_q <= '0;
        else if (restart)
          rc_q <= '0;
        else if (take)
          rc_q <= rc_next;
      end
    end else begin : g_forward
      assign kmer_sel = fwd_next;
    end
  endgenerate

  // Forward window, saturating fill counter and per-sequence emitted flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q     <= '0;
      fill_q    <= '0;
      emitted_q <= 1'b0;
    end else if (start_over) begin
      fwd_q     <= '0;
      fill_q    <= '0;
      emitted_q <= 1'b0;
    end else begin
      if (restart) begin
        fwd_q  <= '0;
        fill_q <= '0;
      end else if (take) begin
        fwd_q  <= fwd_next;
        fill_q <= (fill_q == CNT_W'(KMER_LEN)) ? fill_q : fill_q + CNT_W'(1);
      end
      if (seq_end)
        emitted_q <= 1'b0;
      else if (emit)
        emitted_q <= 1'b1;
    end
  end

  // Output register: loads on emit, drains on handshake, holds otherwise;
  // short_seq flags a sequence end with nothing emitted since its start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_kmer_q  <= '0;
      out_last_q  <= 1'b0;
      short_q     <= 1'b0;
    end else if (start_over) begin
      out_valid_q <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      short_q <= seq_end & ~emitted_q & ~emit;
      if (emit) begin
        out_valid_q <= 1'b1;
        out_kmer_q  <= OUT_KMER'(kmer_sel);
        out_last_q  <= bus.in_last;
      end else if (out_valid_q & bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_kmer  = out_kmer_q;
  assign bus.out_last  = out_last_q;
  assign short_seq     = short_q;
  assign fill_count    = fill_q;
  assign full          = (fill_q == CNT_W'(KMER_LEN));

endmodule

// File: tb/tb_proj_kmer_window.sv
// Directed bench for proj_kmer_window with KMER_LEN=4, 2-bit bases.
// A forward-mode and a canonical-mode instance see the same input stream;
// their handshake timing is identical, only out_kmer differs.
module tb_proj_kmer_window;

  localparam logic [1:0] A = 2'b00;
  localparam logic [1:0] C = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] T = 2'b11;

  logic       clk;
  logic       rst;
  logic       start_over;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_amb;
  logic       in_last;
  logic       out_ready;

  logic       short_c, short_f;
  logic [2:0] fill_c, fill_f;
  logic       full_c, full_f;

  int total_checks;
  int failed_checks;

  proj_kmer_window_if #(.DATA_BITS(2), .OUT_KMER(8)) if_c ();
  proj_kmer_window_if #(.DATA_BITS(2), .OUT_KMER(8)) if_f ();

  assign if_c.in_valid  = in_valid;
  assign if_c.in_data   = in_data;
  assign if_c.in_amb    = in_amb;
  assign if_c.in_last   = in_last;
  assign if_c.out_ready = out_ready;
  assign if_f.in_valid  = in_valid;
  assign if_f.in_data   = in_data;
  assign if_f.in_amb    = in_amb;
  assign if_f.in_last   = in_last;
  assign if_f.out_ready = out_ready;

  proj_kmer_window #(.DATA_BITS(2), .KMER_LEN(4), .CANON_EN(1)) dut_canon (
    .clk        (clk),
    .rst        (rst),
    .start_over (start_over),
    .bus        (if_c),
    .short_seq  (short_c),
    .fill_count (fill_c),
    .full       (full_c)
  );

  proj_kmer_window #(.DATA_BITS(2), .KMER_LEN(4), .CANON_EN(0)) dut_fwd (
    .clk        (clk),
    .rst        (rst),
    .start_over (start_over),
    .bus        (if_f),
    .short_seq  (short_f),
    .fill_count (fill_f),
    .full       (full_f)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with both values
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected)
    else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one base for one clock edge, then sample 1 unit after the edge
  task automatic applyStimulus(input logic [1:0] d, input logic amb, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_amb   = amb;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_amb   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flushPulse();
    start_over = 1'b1;
    @(posedge clk);
    #1;
    start_over = 1'b0;
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    rst        = 1'b1;
    start_over = 1'b0;
    in_valid   = 1'b0;
    in_data    = 2'b00;
    in_amb     = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", if_c.in_ready, 0);
    checkOutput("rst_out_valid", if_c.out_valid, 0);
    checkOutput("rst_out_kmer", if_c.out_kmer, 0);
    checkOutput("rst_fill", fill_c, 0);
    checkOutput("rst_full", full_c, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", if_c.in_ready, 1);

    // Fill A,C,G,T then one more base A
    applyStimulus(A, 0, 0);
    checkOutput("fill_1", fill_c, 1);
    checkOutput("no_emit_1", if_c.out_valid, 0);
    applyStimulus(C, 0, 0);
    checkOutput("fill_2", fill_c, 2);
    applyStimulus(G, 0, 0);
    checkOutput("fill_3", fill_c, 3);
    checkOutput("no_emit_3", if_c.out_valid, 0);
    checkOutput("not_full_3", full_c, 0);
    applyStimulus(T, 0, 0);
    checkOutput("acgt_valid", if_c.out_valid, 1);
    checkOutput("acgt_canon", if_c.out_kmer, 8'h1B);
    checkOutput("acgt_fwd", if_f.out_kmer, 8'h1B);
    checkOutput("acgt_full", full_c, 1);
    applyStimulus(A, 0, 0);
    checkOutput("cgta_valid", if_c.out_valid, 1);
    checkOutput("cgta_canon", if_c.out_kmer, 8'h6C);
    checkOutput("cgta_fwd", if_f.out_kmer, 8'h6C);
    idleCycle();
    checkOutput("drain_valid", if_c.out_valid, 0);
    flushPulse();
    checkOutput("flush_fill", fill_c, 0);

    // T,T,T,T,T: forward 0xFF, canonical 0x00, fill saturates
    applyStimulus(T, 0, 0);
    checkOutput("tttt_fill_1", fill_f, 1);
    applyStimulus(T, 0, 0);
    applyStimulus(T, 0, 0);
    checkOutput("tttt_full_3", full_f, 0);
    applyStimulus(T, 0, 0);
    checkOutput("tttt_fill_4", fill_f, 4);
    checkOutput("tttt_full_4", full_f, 1);
    checkOutput("tttt_fwd", if_f.out_kmer, 8'hFF);
    checkOutput("tttt_canon", if_c.out_kmer, 8'h00);
    applyStimulus(T, 0, 0);
    checkOutput("tttt_fill_sat", fill_f, 4);
    checkOutput("tttt5_valid", if_f.out_valid, 1);
    checkOutput("tttt5_fwd", if_f.out_kmer, 8'hFF);
    idleCycle();
    flushPulse();

    // Ambiguous restart: A,C,N,G,T,A,C (GTAC is its own reverse complement)
    applyStimulus(A, 0, 0);
    applyStimulus(C, 0, 0);
    applyStimulus(A, 1, 0);
    checkOutput("amb_fill", fill_c, 0);
    checkOutput("amb_no_emit", if_c.out_valid, 0);
    applyStimulus(G, 0, 0);
    applyStimulus(T, 0, 0);
    applyStimulus(A, 0, 0);
    checkOutput("amb_fill_3", fill_c, 3);
    checkOutput("amb_no_emit_3", if_c.out_valid, 0);
    applyStimulus(C, 0, 0);
    checkOutput("gtac_valid", if_c.out_valid, 1);
    checkOutput("gtac_fwd", if_f.out_kmer, 8'hB1);
    checkOutput("gtac_canon", if_c.out_kmer, 8'hB1);
    idleCycle();

    // Backpressure: emit TACG while stalled, hold it, then release
    out_ready = 1'b0;
    applyStimulus(G, 0, 0);
    checkOutput("bp_valid", if_c.out_valid, 1);
    in_valid = 1'b1;
    in_data  = T;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", if_c.in_ready, 0);
      checkOutput("bp_hold_fwd", if_f.out_kmer, 8'hC6);
      checkOutput("bp_hold_canon", if_c.out_kmer, 8'h6C);
      @(posedge clk);
      #1;
    end
    checkOutput("bp_fill_held", fill_c, 4);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", if_c.in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_next_valid", if_c.out_valid, 1);
    checkOutput("bp_next_fwd", if_f.out_kmer, 8'h1B);
    checkOutput("bp_next_canon", if_c.out_kmer, 8'h1B);
    idleCycle();
    checkOutput("bp_no_dup", if_c.out_valid, 0);
    flushPulse();

    // Sequence boundaries
    applyStimulus(A, 0, 0);
    applyStimulus(C, 0, 0);
    applyStimulus(G, 0, 0);
    applyStimulus(T, 0, 1);
    checkOutput("last_valid", if_c.out_valid, 1);
    checkOutput("last_flag", if_c.out_last, 1);
    checkOutput("last_kmer", if_c.out_kmer, 8'h1B);
    checkOutput("last_fill", fill_c, 0);
    checkOutput("last_no_short", short_c, 0);
    idleCycle();
    applyStimulus(A, 0, 0);
    applyStimulus(C, 0, 1);
    checkOutput("short_pulse", short_c, 1);
    checkOutput("short_no_emit", if_c.out_valid, 0);
    checkOutput("short_fill", fill_c, 0);
    idleCycle();
    checkOutput("short_drop", short_c, 0);

    // start_over with a stalled k-mer pending
    out_ready = 1'b0;
    applyStimulus(A, 0, 0);
    applyStimulus(C, 0, 0);
    applyStimulus(G, 0, 0);
    applyStimulus(T, 0, 0);
    checkOutput("so_pending", if_c.out_valid, 1);
    start_over = 1'b1;
    #1;
    checkOutput("so_in_ready", if_c.in_ready, 0);
    @(posedge clk);
    #1;
    start_over = 1'b0;
    checkOutput("so_valid", if_c.out_valid, 0);
    checkOutput("so_fill", fill_c, 0);

    // Asynchronous reset mid-cycle with a pending k-mer
    applyStimulus(A, 0, 0);
    applyStimulus(C, 0, 0);
    applyStimulus(G, 0, 0);
    applyStimulus(T, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", if_c.out_valid, 0);
    checkOutput("arst_kmer", if_c.out_kmer, 0);
    checkOutput("arst_fill", fill_c, 0);
    checkOutput("arst_full", full_c, 0);
    checkOutput("arst_in_ready", if_c.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("arst_release_ready", if_c.in_ready, 1);
    applyStimulus(A, 0, 0);
    applyStimulus(C, 0, 0);
    applyStimulus(G, 0, 0);
    applyStimulus(T, 0, 0);
    checkOutput("fresh_valid", if_c.out_valid, 1);
    checkOutput("fresh_canon", if_c.out_kmer, 8'h1B);
    checkOutput("fresh_fwd", if_f.out_kmer, 8'h1B);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
